// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the sequence detector and its statistics blocks.
// Provides default widths/depth and a saturating increment usable up to 32 bits.
package seq_det_pkg;

   localparam int TS_W_DEF  = 16;
   localparam int DEPTH_DEF = 8;
   localparam int CNT_W_DEF = 16;

   // Saturating increment of the low w bits of v; holds at all-ones.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input int unsigned w
   );
      logic [31:0] top;
      top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= top) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; rdata shows the head whenever !empty.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, full, empty, level.
module sync_fifo_fwft #(
   parameter int W     = 16,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);
   assign rdata = mem[rd_ptr];

   assign pop_ok  = pop & ~empty;
   // When full, a simultaneous pop frees the head slot, which is exactly
   // where wr_ptr points, so the write lands behind the remaining entries.
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/match_event_fifo.sv
// Timestamps detector match pulses and buffers them in a FWFT FIFO for the host.
// Ports: clk, rst, match, clr_stats, out_ready -> out_valid, out_ts, level,
//        overflow (sticky drop flag), match_cnt / drop_cnt (saturating).
module match_event_fifo
   import seq_det_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     match,
   input  logic                     clr_stats,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [TS_W-1:0]          out_ts,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [CNT_W-1:0]         match_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   logic [TS_W-1:0] ts;
   logic            full;
   logic            empty;
   logic            pop;
   logic            accept;
   logic            drop;

   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign accept    = match & (~full | pop);
   assign drop      = match & full & ~pop;

   sync_fifo_fwft #(
      .W     (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (match),
      .wdata (ts),
      .pop   (pop),
      .rdata (out_ts),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ts <= '0;
      end else begin
         ts <= ts + TS_W'(1);
      end
   end

   // Clear takes priority over a coincident accept or drop.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         overflow  <= 1'b0;
         match_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (accept) begin
            match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CNT_W));
         end
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
         end
      end
   end

endmodule
